// File: rtl/player_transport_ctrl_if.sv
// Signal bundle between the debounced buttons / address generator (master side)
// and the music player transport controller (slave side).
interface player_transport_ctrl_if #(
  parameter int TRACK_W = 2
);
  logic                 btn_play;
  logic                 btn_stop;
  logic                 btn_next;
  logic                 btn_prev;
  logic                 end_of_track;
  logic [21:0]          offset_addr;
  logic                 count_en;
  logic                 addr_reset;
  logic [TRACK_W-1:0]   track;
  logic                 playing;
  logic [TRACK_W+21:0]  mem_addr;

  modport master (
    output btn_play, btn_stop, btn_next, btn_prev, end_of_track, offset_addr,
    input  count_en, addr_reset, track, playing, mem_addr
  );

  modport slave (
    input  btn_play, btn_stop, btn_next, btn_prev, end_of_track, offset_addr,
    output count_en, addr_reset, track, playing, mem_addr
  );
endinterface

// File: rtl/player_transport_ctrl.sv
// Music player transport controller: button edges -> play state and track number,
// sample-rate count_en strobe and one-cycle addr_reset pulse for the address generator.
module player_transport_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SAMPLE_HZ      = 3000,
  parameter int NUM_TRACKS     = 4,
  parameter int TRACK_W        = 2,
  parameter int RESTART_THRESH = 9000,
  parameter int LOOP_ALL       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  player_transport_ctrl_if.slave  bus
);
  localparam int                 DIV        = CLK_HZ / SAMPLE_HZ;
  localparam int                 PW         = $clog2(DIV);
  localparam logic [PW-1:0]      PRESC_MAX  = PW'(DIV - 1);
  localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [21:0]        THRESH     = 22'(RESTART_THRESH);

  typedef enum logic [1:0] {ST_STOPPED, ST_PLAY, ST_PAUSE, ST_SWITCH} state_t;

  state_t             state, target, sw_target;
  logic [PW-1:0]      presc;
  logic [TRACK_W-1:0] track, track_nxt, track_inc, track_dec;
  logic [4:0]         btn_now, btn_q, ev;
  logic               ev_play, ev_stop, ev_next, ev_prev, ev_eot;
  logic               sw_req;
  logic               count_en_r, addr_reset_r, playing_r;

  // end_of_track is edge-detected like the buttons so a level held across SWITCH acts once.
  assign btn_now = {bus.end_of_track, bus.btn_prev, bus.btn_next, bus.btn_stop, bus.btn_play};
  assign ev      = btn_now & ~btn_q;
  assign {ev_eot, ev_prev, ev_next, ev_stop, ev_play} = ev;

  assign track_inc = (track == LAST_TRACK) ? '0 : track + TRACK_W'(1);
  assign track_dec = (track == '0) ? LAST_TRACK : track - TRACK_W'(1);

  // Event decode in priority order: end_of_track > stop > next > prev (play handled below).
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    sw_req    = 1'b0;
    sw_target = ST_PLAY;
    track_nxt = track;
    case (state)
      ST_STOPPED: begin
        if (!ev_stop) begin
          if (ev_next)      track_nxt = track_inc;
          else if (ev_prev) track_nxt = track_dec;
        end
      end
      ST_PLAY, ST_PAUSE: begin
        if (state == ST_PLAY && ev_eot) begin
          sw_req    = 1'b1;
          track_nxt = track_inc;
          sw_target = (track == LAST_TRACK && LOOP_ALL == 0) ? ST_STOPPED : ST_PLAY;
        end else if (ev_stop) begin
          sw_req    = 1'b1;
          sw_target = ST_STOPPED;
        end else if (ev_next) begin
          sw_req    = 1'b1;
          sw_target = state;
          track_nxt = track_inc;
        end else if (ev_prev) begin
          sw_req    = 1'b1;
          sw_target = state;
          if (bus.offset_addr < THRESH) track_nxt = track_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_STOPPED;
      target       <= ST_STOPPED;
      track        <= '0;
      presc        <= '0;
      btn_q        <= '0;
      count_en_r   <= 1'b0;
      addr_reset_r <= 1'b0;
      playing_r    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
      btn_q        <= btn_now;
      track        <= track_nxt;
      count_en_r   <= 1'b0;
      addr_reset_r <= 1'b0;
      if (sw_req) begin
        state        <= ST_SWITCH;
        target       <= sw_target;
        presc        <= '0;
        addr_reset_r <= 1'b1;
        playing_r    <= (sw_target == ST_PLAY);
      end else begin
        case (state)
          ST_STOPPED: begin
            if (!ev_stop) begin
              if (ev_next || ev_prev) begin
                addr_reset_r <= 1'b1;
              end else if (ev_play) begin
                state     <= ST_PLAY;
                presc     <= '0;
                playing_r <= 1'b1;
              end
            end
          end
          ST_PLAY: begin
            if (ev_play) begin
              state     <= ST_PAUSE;
              playing_r <= 1'b0;
            end else if (presc == PRESC_MAX) begin
              presc      <= '0;
              count_en_r <= 1'b1;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          ST_PAUSE: begin
            if (ev_play) begin
              state     <= ST_PLAY;
              playing_r <= 1'b1;
            end
          end
          ST_SWITCH: begin
            state     <= target;
            presc     <= '0;
            playing_r <= (target == ST_PLAY);
          end
          default: state <= ST_STOPPED;
        endcase
      end
    end
  end

  assign bus.count_en   = count_en_r;
  assign bus.addr_reset = addr_reset_r;
  assign bus.track      = track;
  assign bus.playing    = playing_r;
  assign bus.mem_addr   = {track, bus.offset_addr};
endmodule

// File: tb/tb_player_transport_ctrl.sv
// Scoreboard bench for player_transport_ctrl: DIV=4, 3 tracks, RESTART_THRESH=5, LOOP_ALL=0.
module tb_player_transport_ctrl;
  localparam int TRACK_W = 2;
  localparam logic [1:0] K_CNT  = 2'b10;
  localparam logic [1:0] K_ARST = 2'b01;
  localparam logic [3:0] B_PLAY = 4'b0001;
  localparam logic [3:0] B_STOP = 4'b0010;
  localparam logic [3:0] B_NEXT = 4'b0100;
  localparam logic [3:0] B_PREV = 4'b1000;

  typedef struct {
    logic [1:0]         kind;
    int                 cyc;
    logic [TRACK_W-1:0] track;
    logic               playing;
  } pulse_t;

  logic   clk = 1'b0;
  logic   reset;
  int     cyc;
  int     tests = 0;
  int     fails = 0;
  pulse_t exp_q[$];
  pulse_t mon_p;

  player_transport_ctrl_if #(.TRACK_W(TRACK_W)) bus();

  player_transport_ctrl #(
    .CLK_HZ(12), .SAMPLE_HZ(3), .NUM_TRACKS(3), .TRACK_W(TRACK_W),
    .RESTART_THRESH(5), .LOOP_ALL(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset was released.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] k, input int c,
                              input logic [TRACK_W-1:0] t, input logic p);
    exp_q.push_back('{k, c, t, p});
  endtask

  // Called at a falling edge; the event is seen at the next rising edge, returned in e.
  task automatic press(input logic [3:0] m, output int e);
    {bus.btn_prev, bus.btn_next, bus.btn_stop, bus.btn_play} = m;
    e = cyc + 1;
    @(negedge clk);
    {bus.btn_prev, bus.btn_next, bus.btn_stop, bus.btn_play} = 4'b0000;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every count_en / addr_reset pulse must match the head of the queue.
  always begin
    @(negedge clk);
    #1;
    if (bus.count_en || bus.addr_reset) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, bus.count_en, bus.addr_reset, cyc}, 64'd0);
      end else begin
        mon_p = exp_q.pop_front();
        check(mon_p.kind == K_CNT ? "count_en_pulse" : "addr_reset_pulse",
              {bus.count_en, bus.addr_reset, cyc, bus.track, bus.playing},
              {mon_p.kind, mon_p.cyc, mon_p.track, mon_p.playing});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expected pulses pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int e, p, r, n1, n2, n3, q1, q2, x, s1, s2, z, n4;
    {bus.btn_prev, bus.btn_next, bus.btn_stop, bus.btn_play} = 4'b0000;
    bus.end_of_track = 1'b0;
    bus.offset_addr  = 22'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_track",      bus.track,      0);
    check("reset_playing",    bus.playing,    0);
    check("reset_count_en",   bus.count_en,   0);
    check("reset_addr_reset", bus.addr_reset, 0);
    check("reset_mem_addr",   bus.mem_addr,   0);

    // Play from STOPPED: count_en 4, 8, 12 cycles after entry.
    press(B_PLAY, e);
    check("play_playing", bus.playing, 1);
    for (int k = 1; k <= 3; k++) expect_pulse(K_CNT, e + 4 * k, 2'd0, 1'b1);

    // Pause with prescaler at 2, hold 20 cycles, resume: count_en 2 cycles after resume.
    wait_until(e + 14);
    press(B_PLAY, p);
    check("pause_playing", bus.playing, 0);
    repeat (20) @(negedge clk);
    press(B_PLAY, r);
    check("resume_playing", bus.playing, 1);
    expect_pulse(K_CNT, r + 2, 2'd0, 1'b1);

    // next twice to reach track 2, then next wraps modulo 3 to track 0.
    wait_until(r + 2);
    press(B_NEXT, n1);
    expect_pulse(K_ARST, n1, 2'd1, 1'b1);
    @(negedge clk);
    press(B_NEXT, n2);
    expect_pulse(K_ARST, n2, 2'd2, 1'b1);
    expect_pulse(K_CNT, n2 + 5, 2'd2, 1'b1);
    wait_until(n2 + 5);
    press(B_NEXT, n3);
    expect_pulse(K_ARST, n3, 2'd0, 1'b1);
    expect_pulse(K_CNT, n3 + 5, 2'd0, 1'b1);
    expect_pulse(K_CNT, n3 + 9, 2'd0, 1'b1);

    // prev with offset 7 restarts track 0; prev with offset 3 wraps to track 2.
    wait_until(n3 + 9);
    bus.offset_addr = 22'd7;
    press(B_PREV, q1);
    expect_pulse(K_ARST, q1, 2'd0, 1'b1);
    expect_pulse(K_CNT, q1 + 5, 2'd0, 1'b1);
    wait_until(q1 + 5);
    bus.offset_addr = 22'd3;
    press(B_PREV, q2);
    expect_pulse(K_ARST, q2, 2'd2, 1'b1);
    expect_pulse(K_CNT, q2 + 5, 2'd2, 1'b1);
    check("mem_addr_concat", bus.mem_addr, {2'd2, 22'd3});

    // end_of_track on the last track with LOOP_ALL=0 stops; holding it does nothing more.
    wait_until(q2 + 5);
    bus.end_of_track = 1'b1;
    x = cyc + 1;
    expect_pulse(K_ARST, x, 2'd0, 1'b0);
    repeat (10) @(negedge clk);
    bus.end_of_track = 1'b0;
    check("eot_stop_playing", bus.playing, 0);
    check("eot_stop_track",   bus.track,   0);

    // STOPPED: prev ignores the restart threshold and wraps, next wraps back.
    bus.offset_addr = 22'd7;
    press(B_PREV, s1);
    expect_pulse(K_ARST, s1, 2'd2, 1'b0);
    press(B_NEXT, s2);
    expect_pulse(K_ARST, s2, 2'd0, 1'b0);
    check("stopped_playing", bus.playing, 0);

    // next and stop together while playing: stop wins, track unchanged.
    bus.offset_addr = 22'd0;
    press(B_PLAY, e);
    press(B_NEXT | B_STOP, z);
    expect_pulse(K_ARST, z, 2'd0, 1'b0);
    check("stop_wins_switch_playing", bus.playing, 0);
    @(negedge clk);
    check("stop_wins_playing", bus.playing, 0);
    check("stop_wins_track",   bus.track,   0);

    // Reset asserted mid-SWITCH aborts the pulse immediately.
    press(B_PLAY, e);
    press(B_NEXT, n4);
    expect_pulse(K_ARST, n4, 2'd1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midswitch_addr_reset", bus.addr_reset, 0);
    check("midswitch_track",      bus.track,      0);
    check("midswitch_playing",    bus.playing,    0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("pulses_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/player_transport_ctrl.md
Name: player_transport_ctrl

Overview:
- Transport controller for the music player. Turns the play/pause, stop, next and previous buttons into a play state and a current track number.
- Feeds the per-track address generator with a sample-rate `count_en` strobe and a one-cycle `addr_reset` pulse.
- Builds the full memory address as the track number followed by the 22-bit offset.
- Sits between the debounced button inputs and the address generator / sample memory.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- SAMPLE_HZ, 3000, sample (address-advance) rate. DIV = CLK_HZ/SAMPLE_HZ; it must be ≥ 2.
- NUM_TRACKS, 4, number of tracks in memory. Range 2..2^TRACK_W.
- TRACK_W, 2, track index width.
- RESTART_THRESH, 9000, offset (3 s at 3 kHz) at or above which "prev" restarts the current track instead of going back one track.
- LOOP_ALL, 1, 1 = wrap to track 0 after the last track ends; 0 = stop after the last track.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- btn_play, input, 1, debounced level; a rising edge toggles play/pause.
- btn_stop, input, 1, debounced level; a rising edge stops and rewinds.
- btn_next, input, 1, debounced level; a rising edge selects the next track.
- btn_prev, input, 1, debounced level; a rising edge restarts the current track or selects the previous one.
- end_of_track, input, 1, high when the address generator's offset has reached its maximum.
- offset_addr, input, 22, current offset from the address generator.
- count_en, output, 1, one-clock strobe at SAMPLE_HZ while playing.
- addr_reset, output, 1, one-clock pulse that clears the address generator offset.
- track, output, TRACK_W, current track index.
- playing, output, 1, high in PLAY.
- mem_addr, output, TRACK_W+22, combinational concatenation: track in the upper bits, offset_addr in the lower 22 bits.

Behaviour:

Reset (async):
- state = STOPPED, track = 0.
- Prescaler = 0, edge registers = 0, resume target = STOPPED.
- count_en = 0, addr_reset = 0, playing = 0.

Edge detection:
- Each button is registered every clk.
- An event fires in the cycle where the input is 1 and its registered copy is 0.
- A button held high produces exactly one event.
- The state and all registered outputs update on the same clk edge at which the event is seen (latency 1 edge).

Event priority when several fire in one cycle: end_of_track > stop > next > prev > play. Lower-priority events in that cycle are discarded.

States: STOPPED, PLAY, PAUSE, SWITCH.

STOPPED:
- play: go to PLAY. No addr_reset; the offset is already 0.
- next: track+1 (wraps), stay STOPPED, pulse addr_reset.
- prev: track−1 (wraps from 0 to NUM_TRACKS−1), stay STOPPED, pulse addr_reset. The RESTART_THRESH rule is not applied here.
- stop: no effect.

PLAY:
- Prescaler counts 0..DIV−1. count_en = 1 in the cycle the prescaler wraps from DIV−1 to 0.
- play: go to PAUSE; the prescaler freezes at its current value.
- stop: go to SWITCH with target STOPPED; track is unchanged.
- next: track+1 (wraps); go to SWITCH with target PLAY.
- prev with offset_addr ≥ RESTART_THRESH: track unchanged; go to SWITCH with target PLAY.
- prev with offset_addr < RESTART_THRESH: track−1 (wraps); go to SWITCH with target PLAY.
- end_of_track:
  - track < NUM_TRACKS−1: track+1; go to SWITCH with target PLAY.
  - Last track, LOOP_ALL=1: track = 0; go to SWITCH with target PLAY.
  - Last track, LOOP_ALL=0: track = 0; go to SWITCH with target STOPPED.

PAUSE:
- count_en = 0; the prescaler holds its value.
- play: return to PLAY and resume from the held prescaler value.
- stop, next and prev: same as in PLAY, but the target is PAUSE instead of PLAY (stop still targets STOPPED).
- end_of_track is ignored; it cannot advance without count_en.

SWITCH (exactly 1 cycle):
- addr_reset = 1, count_en = 0, prescaler cleared to 0.
- Next state = stored target. All button events during SWITCH are ignored, but the edge registers still update.

Outputs and timing:
- addr_reset and count_en are registered and never high in the same cycle.
- playing = (state == PLAY); it stays high during a SWITCH whose target is PLAY.
- First count_en after entering PLAY from SWITCH or STOPPED: DIV cycles after entry.

Boundary conditions:
- Track arithmetic is modulo NUM_TRACKS, not 2^TRACK_W.
- end_of_track held high across SWITCH must not cause a second advance. It is acted on only in PLAY and only on its rising edge (registered, like the buttons).
- If reset asserts mid-SWITCH, the pulse is aborted immediately and all reset values apply.

Test Plan (CLK_HZ=12, SAMPLE_HZ=3 → DIV=4; NUM_TRACKS=3; TRACK_W=2; RESTART_THRESH=5):
- Reset, then pulse btn_play → playing=1; count_en pulses on cycles 4, 8, 12 after entry and is low in all other cycles.
- In PLAY, press play after 2 prescaler counts, wait 20 cycles, press play again → no count_en while paused; the first count_en after resume comes 2 cycles after resume.
- In PLAY at track=2, press btn_next → addr_reset high for exactly 1 cycle, track=0, count_en resumes 4 cycles later.
- Press btn_prev with offset_addr=7 → track unchanged, one addr_reset pulse. Press with offset_addr=3 at track=0 → track=2, one addr_reset pulse.
- end_of_track rises on track=2: with LOOP_ALL=0 → STOPPED, track=0, playing=0, one addr_reset; holding end_of_track high for 10 cycles causes no further action.
- Assert btn_next and btn_stop in the same cycle in PLAY → stop wins: SWITCH then STOPPED, track unchanged. Assert reset during SWITCH → addr_reset drops immediately and track=0.
